// File: rtl/spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : spi_regfile_peripheral
// Description : SPI mode-0 (MSB first) register-file peripheral running in the
//               system clock domain. Frames are {RW, ADDR, DATA}; writes
//               commit after chip-select rises, reads stream a register out
//               on cipo during the data phase.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int HDR_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_DATA    = 3'd2,
    S_COMMIT  = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  // Synchroniser chains and edge-detect history (no reset: they only track pins)
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ncs_prev_q,  ncs_prev_d;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  // Protocol state
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  shift_in_q, shift_in_d;
  logic [DATA_W-1:0]   shift_out_q, shift_out_d;
  logic                rd_q, rd_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                cipo_q, cipo_d;
  logic                cipo_oe_q, cipo_oe_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                frame_err_q, frame_err_d;

  // Frame field views
  logic [FRAME_W-1:0]  shift_in_nxt;
  logic [ADDR_W-1:0]   hdr_addr;
  logic                hdr_rw;
  logic [ADDR_W-1:0]   cm_addr;
  logic [DATA_W-1:0]   cm_data;
  logic                cm_rw;
  logic [DATA_W-1:0]   rd_word;
  logic                cm_hit;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  // sclk edges only count while the frame is selected; ncs edges always count
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~ncs_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~ncs_s;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  assign shift_in_nxt = {shift_in_q[FRAME_W-2:0], copi_s};
  assign hdr_addr     = shift_in_nxt[ADDR_W-1:0];
  assign hdr_rw       = shift_in_nxt[ADDR_W];
  assign cm_rw        = shift_in_q[FRAME_W-1];
  assign cm_addr      = shift_in_q[DATA_W +: ADDR_W];
  assign cm_data      = shift_in_q[DATA_W-1:0];

  // Next values for the synchroniser chains and edge history
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    sclk_prev_d = sclk_s;
    ncs_prev_d  = ncs_s;
  end

  // Clock the SPI pins into the system domain
  always_ff @(posedge clk) begin
    sclk_sync_q <= sclk_sync_d;
    ncs_sync_q  <= ncs_sync_d;
    copi_sync_q <= copi_sync_d;
    sclk_prev_q <= sclk_prev_d;
    ncs_prev_q  <= ncs_prev_d;
  end

  // Register lookups: read data for the header address, hit flag for commit
  always_comb begin
    rd_word = '0;
    cm_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr == ADDR_W'(i)) rd_word = regs_q[i];
      if (cm_addr == ADDR_W'(i))  cm_hit  = 1'b1;
    end
  end

  // Frame state machine: shift, decode, commit
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    rd_d        = rd_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d   = '0;
        shift_in_d  = '0;
        shift_out_d = '0;
        rd_d        = 1'b0;
        if (ncs_fall) state_d = S_CMD;
      end
      S_CMD: begin
        if (ncs_rise) begin
          state_d = S_COMMIT;
        end else if (sclk_rise) begin
          shift_in_d = shift_in_nxt;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(HDR_W - 1)) begin
            // Header complete: a read preloads the addressed register
            state_d     = S_DATA;
            rd_d        = ~hdr_rw;
            shift_out_d = hdr_rw ? '0 : rd_word;
          end
        end
      end
      S_DATA: begin
        if (ncs_rise) begin
          state_d = S_COMMIT;
        end else begin
          if (sclk_rise) begin
            shift_in_d = shift_in_nxt;
            if (bit_cnt_q != CNT_W'(FRAME_W + 1)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          // The fall right after the header keeps the MSB on cipo for data bit 1
          if (sclk_fall && rd_q && (bit_cnt_q > CNT_W'(HDR_W)))
            shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (bit_cnt_q != CNT_W'(FRAME_W)) begin
          frame_err_d = 1'b1;
        end else if (cm_rw && cm_hit) begin
          for (int i = 0; i < NUM_REGS; i++)
            if (cm_addr == ADDR_W'(i)) regs_d[i] = cm_data;
          wr_strobe_d = 1'b1;
          wr_addr_d   = cm_addr;
        end
      end
      S_LOCKOUT: begin
        if (ncs_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cipo_d    = (state_d == S_DATA) & rd_d & shift_out_d[DATA_W-1];
    cipo_oe_d = ~ncs_s & (state_d != S_LOCKOUT);
  end

  // State and output registers; a frame caught mid-flight at reset is locked out
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ncs_s ? S_IDLE : S_LOCKOUT;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      rd_q        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      rd_q        <= rd_d;
      regs_q      <= regs_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo      = cipo_q;
  assign cipo_oe   = cipo_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_regfile_peripheral
// Description : Scoreboard bench for spi_regfile_peripheral. Two instances:
//               default geometry (16-bit frames) and 8x16-bit regs with
//               3-bit addresses (20-bit frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_regfile_peripheral;

  localparam int SS  = 2;
  localparam int NR1 = 5, AW1 = 7, DW1 = 8,  FW1 = 16;
  localparam int NR2 = 8, AW2 = 3, DW2 = 16, FW2 = 20;
  localparam int HP  = 6;  // sclk half period in clk cycles

  typedef struct packed {
    logic        is_err;
    logic [7:0]  addr;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sclk = 2'b00, ncs = 2'b11, copi = 2'b00;
  logic [1:0] cipo, cipo_oe, wr_strobe, frame_err;
  logic [NR1*DW1-1:0] regs1;
  logic [NR2*DW2-1:0] regs2;
  logic [AW1-1:0] wr_addr1;
  logic [AW2-1:0] wr_addr2;

  int n_checks = 0, n_pass = 0, cyc = 0;
  int rise_cyc [2] = '{0, 0};
  ev_t         q_ev [2][$];
  logic [15:0] q_rd [2][$];
  logic [15:0] m1 [NR1];
  logic [15:0] m2 [NR2];

  // monitor-side SPI bus tracking
  logic [1:0]  p_sclk = 2'b00, p_ncs = 2'b11;
  int          rbits [2] = '{0, 0};
  logic        rw [2] = '{1'b1, 1'b1};
  logic [63:0] rsh [2] = '{64'd0, 64'd0};

  spi_regfile_peripheral dut1 (
    .clk(clk), .rst(rst), .sclk(sclk[0]), .ncs(ncs[0]), .copi(copi[0]),
    .cipo(cipo[0]), .cipo_oe(cipo_oe[0]), .regs_flat(regs1),
    .wr_strobe(wr_strobe[0]), .wr_addr(wr_addr1), .frame_err(frame_err[0])
  );

  spi_regfile_peripheral #(.NUM_REGS(NR2), .ADDR_W(AW2), .DATA_W(DW2), .SYNC_STAGES(SS)) dut2 (
    .clk(clk), .rst(rst), .sclk(sclk[1]), .ncs(ncs[1]), .copi(copi[1]),
    .cipo(cipo[1]), .cipo_oe(cipo_oe[1]), .regs_flat(regs2),
    .wr_strobe(wr_strobe[1]), .wr_addr(wr_addr2), .frame_err(frame_err[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [15:0] reg_at(input int s, input int a);
    if (s == 0) return 16'(regs1[a*DW1 +: DW1]);
    return regs2[a*DW2 +: DW2];
  endfunction

  function automatic logic [7:0] addr_of(input int s);
    if (s == 0) return 8'(wr_addr1);
    return 8'(wr_addr2);
  endfunction

  function automatic int fw(input int s);
    return (s == 0) ? FW1 : FW2;
  endfunction

  function automatic logic [15:0] dmask(input int s);
    return (s == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  // Monitor: pops expected strobe/error events and completed read frames
  always @(negedge clk) begin
    p_sclk <= sclk;
    p_ncs  <= ncs;
    for (int s = 0; s < 2; s++) begin
      if (wr_strobe[s] || frame_err[s]) begin
        if (q_ev[s].size() == 0) begin
          chk($sformatf("dut%0d unexpected strobe/err", s + 1), {wr_strobe[s], frame_err[s]}, 2'b00);
        end else begin
          chk($sformatf("dut%0d event kind", s + 1), frame_err[s], q_ev[s][0].is_err);
          chk($sformatf("dut%0d event latency", s + 1), cyc - rise_cyc[s], SS + 2);
          if (!q_ev[s][0].is_err) begin
            chk($sformatf("dut%0d wr_addr", s + 1), addr_of(s), q_ev[s][0].addr);
            chk($sformatf("dut%0d written reg", s + 1), reg_at(s, int'(q_ev[s][0].addr)), q_ev[s][0].data);
          end
          q_ev[s].delete(0);
        end
      end
      if (!ncs[s] && p_ncs[s]) begin
        rbits[s] <= 0;
      end else if (!ncs[s] && sclk[s] && !p_sclk[s]) begin
        if (rbits[s] == 0) rw[s] <= copi[s];
        rsh[s]   <= {rsh[s][62:0], cipo[s]};
        rbits[s] <= rbits[s] + 1;
      end
      if (ncs[s] && !p_ncs[s] && rbits[s] == fw(s) && !rw[s]) begin
        if (q_rd[s].size() == 0) begin
          chk($sformatf("dut%0d read expected", s + 1), q_rd[s].size(), 1);
        end else begin
          chk($sformatf("dut%0d read data", s + 1), rsh[s][15:0] & dmask(s), q_rd[s][0]);
          q_rd[s].delete(0);
        end
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_regs();
    for (int i = 0; i < NR1; i++) chk($sformatf("dut1 reg%0d", i), reg_at(0, i), m1[i]);
    for (int i = 0; i < NR2; i++) chk($sformatf("dut2 reg%0d", i), reg_at(1, i), m2[i]);
  endtask

  task automatic clear_models();
    for (int i = 0; i < NR1; i++) m1[i] = '0;
    for (int i = 0; i < NR2; i++) m2[i] = '0;
  endtask

  // Drive one frame of nb bits (v right-aligned, MSB sent first); optional reset pulse after bit 8
  task automatic frame(input int s, input int nb, input logic [31:0] v, input bit rst_mid);
    bit lk = 1'b0;
    ncs[s] = 1'b0;
    wclk(HP);
    for (int i = nb - 1; i >= 0; i--) begin
      copi[s] = v[i];
      wclk(HP);
      sclk[s] = 1'b1;
      wclk(HP);
      sclk[s] = 1'b0;
      if (rst_mid && i == nb - 8) begin
        rst = 1'b1;
        wclk(1);
        rst = 1'b0;
        lk = 1'b1;
        clear_models();
        check_regs();
        chk("post-reset wr_addr", addr_of(s), 8'h00);
        chk("post-reset wr_strobe", wr_strobe[s], 1'b0);
        chk("post-reset frame_err", frame_err[s], 1'b0);
        chk("post-reset cipo_oe (lockout)", cipo_oe[s], 1'b0);
      end
      if (i == nb - 12) chk($sformatf("dut%0d cipo_oe mid-frame", s + 1), cipo_oe[s], !lk);
    end
    wclk(HP);
    ncs[s] = 1'b1;
    rise_cyc[s] = cyc;
    copi[s] = 1'b0;
    wclk(HP + SS + 4);
    chk($sformatf("dut%0d cipo_oe idle", s + 1), cipo_oe[s], 1'b0);
    chk($sformatf("dut%0d cipo idle", s + 1), cipo[s], 1'b0);
  endtask

  task automatic wr1(input int a, input int d);
    if (a < NR1) begin
      q_ev[0].push_back('{1'b0, 8'(a), 16'(d)});
      m1[a] = 16'(d);
    end
    frame(0, FW1, {16'h0000, 1'b1, 7'(a), 8'(d)}, 1'b0);
  endtask

  task automatic rd1(input int a, input logic [15:0] exp);
    q_rd[0].push_back(exp);
    frame(0, FW1, {16'h0000, 1'b0, 7'(a), 8'h00}, 1'b0);
  endtask

  task automatic err1(input int nb, input logic [31:0] v);
    q_ev[0].push_back('{1'b1, 8'h00, 16'h0000});
    frame(0, nb, v, 1'b0);
  endtask

  initial begin
    clear_models();
    wclk(6);
    // reset values while rst is held
    check_regs();
    chk("reset cipo", cipo, 2'b00);
    chk("reset cipo_oe", cipo_oe, 2'b00);
    chk("reset wr_strobe", wr_strobe, 2'b00);
    chk("reset frame_err", frame_err, 2'b00);
    chk("reset wr_addr1", addr_of(0), 8'h00);
    chk("reset wr_addr2", addr_of(1), 8'h00);
    rst = 1'b0;
    wclk(4);

    // basic write to reg4
    wr1(4, 'hA5);
    check_regs();

    // write reg0 then read it back, plus read of reg4
    wr1(0, 'h55);
    rd1(0, 16'h0055);
    rd1(4, 16'h00A5);
    check_regs();

    // wrong-length frames carrying write 0x8233, then an empty frame
    err1(15, 32'h0000_4119);
    err1(17, 32'h0001_0466);
    err1(0, 32'h0);
    check_regs();

    // out-of-range address: silently ignored, reads as zero
    frame(0, FW1, 32'h0000_9077, 1'b0);
    check_regs();
    rd1('h10, 16'h0000);

    // reset in the middle of a write frame: frame must not commit
    frame(0, FW1, 32'h0000_83FF, 1'b1);
    check_regs();
    wr1(3, 'hFF);
    rd1(3, 16'h00FF);
    check_regs();

    // wide geometry: 20-bit frames
    q_ev[1].push_back('{1'b0, 8'd7, 16'hBEEF});
    m2[7] = 16'hBEEF;
    frame(1, FW2, 32'h000F_BEEF, 1'b0);
    q_rd[1].push_back(16'hBEEF);
    frame(1, FW2, 32'h0007_0000, 1'b0);
    check_regs();

    wclk(10);
    chk("pending strobe/err events", q_ev[0].size() + q_ev[1].size(), 0);
    chk("pending reads", q_rd[0].size() + q_rd[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
